// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit for the datapath.
// Runs fetch (T0-T2) with a memory wait in T1, decodes IR in T3 and then
// sequences one register-to-register ALU instruction before returning to T0.
// All strobes are Moore-decoded from the current state plus the IR fields.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Read,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        run,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // Two-operand ops: ADD through DIV occupy the contiguous codes 0..10.
  function automatic logic is_binary(input logic [4:0] op);
    return op <= OP_DIV;
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // MUL/DIV produce a 64-bit result and need the extra HI/LO step.
  function automatic logic is_wide(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [3:0]  rc_q, rc_d;

  logic [4:0]  op_cur;
  logic [3:0]  ra_cur, rb_cur, rc_cur;
  logic        alu_en;

  // The low immediate bits of IR are not used by register-to-register ops.
  logic [14:0] unused_ir_bits;
  assign unused_ir_bits = IR[14:0];

  // Fields come straight from IR during decode and from the captured copy after,
  // so the instruction stays stable even if the datapath reloads IR later.
  always_comb begin
    if (state_q == S_T3) begin
      op_cur = IR[31:27];
      ra_cur = IR[26:23];
      rb_cur = IR[22:19];
      rc_cur = IR[18:15];
    end else begin
      op_cur = op_q;
      ra_cur = ra_q;
      rb_cur = rb_q;
      rc_cur = rc_q;
    end
    op_d = op_cur;
    ra_d = ra_cur;
    rb_d = rb_cur;
    rc_d = rc_cur;
  end

  // Next-state sequencing through fetch, memory wait, decode and execute.
  always_comb begin
    // NOTE: assign a default before the case so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_binary(op_cur) || is_unary(op_cur)) state_d = S_T4;
        else if (op_cur == OP_HALT)                state_d = S_HALT;
        else                                       state_d = S_T0;
      end
      S_T4:   state_d = is_binary(op_cur) ? S_T5 : S_T0;
      S_T5:   state_d = is_wide(op_cur) ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Moore decode of all datapath strobes from the current state and fields.
  always_comb begin
    Rin      = '0;
    Rout     = '0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Read     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    AND      = 1'b0;
    OR       = 1'b0;
    ADD      = 1'b0;
    SUB      = 1'b0;
    MUL      = 1'b0;
    DIV      = 1'b0;
    SHR      = 1'b0;
    SHRA     = 1'b0;
    SHL      = 1'b0;
    ROR      = 1'b0;
    ROL      = 1'b0;
    NEG      = 1'b0;
    NOT      = 1'b0;
    run      = 1'b0;
    illegal  = 1'b0;
    alu_en   = 1'b0;

    case (state_q)
      S_T0: begin
        run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
      end
      S_T1: begin
        run   = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (is_binary(op_cur)) begin
          Rout = onehot16(rb_cur);
          Yin  = 1'b1;
        end else if (is_unary(op_cur)) begin
          Rout   = onehot16(rb_cur);
          alu_en = 1'b1;
          Zin    = 1'b1;
        end else if (op_cur != OP_HALT) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1;
        if (is_binary(op_cur)) begin
          Rout   = onehot16(rc_cur);
          alu_en = 1'b1;
          Zin    = 1'b1;
        end else begin
          Zlowout = 1'b1;
          Rin     = onehot16(ra_cur);
        end
      end
      S_T5: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        if (is_wide(op_cur)) LOin = 1'b1;
        else                 Rin  = onehot16(ra_cur);
      end
      S_T6: begin
        run      = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase

    if (alu_en) begin
      case (op_cur)
        OP_ADD:  ADD  = 1'b1;
        OP_SUB:  SUB  = 1'b1;
        OP_AND:  AND  = 1'b1;
        OP_OR:   OR   = 1'b1;
        OP_SHR:  SHR  = 1'b1;
        OP_SHRA: SHRA = 1'b1;
        OP_SHL:  SHL  = 1'b1;
        OP_ROR:  ROR  = 1'b1;
        OP_ROL:  ROL  = 1'b1;
        OP_MUL:  MUL  = 1'b1;
        OP_DIV:  DIV  = 1'b1;
        OP_NEG:  NEG  = 1'b1;
        OP_NOT:  NOT  = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

  // State and captured instruction fields; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      state_q <= S_RST;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a per-instruction step-list
// model builds the expected output vector for every cycle, one compare
// process checks the DUT at each falling edge, and literal checks pin the model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Yin, Zin;
  logic Zlowout, Zhighout, HIin, LOin;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic run, illegal;
  logic [3:0] state;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR(IR), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Read(Read),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT),
    .run(run), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // alu bit n is the select for opcode n (ADD=0 ... NOT=12).
  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcout, pcin, incpc, marin, mdrin, mdrout, irin, read;
    logic yin, zin, zlowout, zhighout, hiin, loin;
    logic [12:0] alu;
    logic run, illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    outs_t e;
    logic  mr;
  } step_t;

  int     n_checks = 0;
  int     n_pass   = 0;
  outs_t  exp_now;
  bit     exp_valid = 1'b0;
  outs_t  hist[$];
  step_t  plan[$];
  outs_t  cur;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.rin = Rin; s.rout = Rout;
    s.pcout = PCout; s.pcin = PCin; s.incpc = IncPC; s.marin = MARin;
    s.mdrin = MDRin; s.mdrout = MDRout; s.irin = IRin; s.read = Read;
    s.yin = Yin; s.zin = Zin; s.zlowout = Zlowout; s.zhighout = Zhighout;
    s.hiin = HIin; s.loin = LOin;
    s.alu = {NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD};
    s.run = run; s.illegal = illegal; s.state = state;
    return s;
  endfunction

  // Compare process: record every cycle and check it against the model.
  always @(negedge clk) begin
    cur = sample();
    hist.push_back(cur);
    if (exp_valid)
      check($sformatf("cycle%0d", hist.size() - 1), 128'(cur), 128'(exp_now));
  end

  function automatic outs_t blank(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    o.run = (st >= 4'd1) && (st <= 4'd7);
    return o;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic push(input outs_t e, input logic mr);
    step_t s;
    s.e = e;
    s.mr = mr;
    plan.push_back(s);
  endtask

  // Model: expected output vector for each cycle of one instruction, T0 onward.
  task automatic build(input logic [31:0] ir, input int wait_n);
    outs_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    plan.delete();
    e = blank(4'd1); e.pcout = 1; e.marin = 1; e.incpc = 1; e.pcin = 1;
    push(e, 1'b1);
    for (int w = 0; w <= wait_n; w++) begin
      e = blank(4'd2); e.read = 1; e.mdrin = 1;
      push(e, (w == wait_n));
    end
    e = blank(4'd3); e.mdrout = 1; e.irin = 1;
    push(e, 1'b1);
    if (op <= 5'd10) begin
      e = blank(4'd4); e.rout = 16'd1 << rb; e.yin = 1; push(e, 1'b1);
      e = blank(4'd5); e.rout = 16'd1 << rc; e.alu = 13'd1 << op; e.zin = 1; push(e, 1'b1);
      if (op == 5'd9 || op == 5'd10) begin
        e = blank(4'd6); e.zlowout = 1; e.loin = 1; push(e, 1'b1);
        e = blank(4'd7); e.zhighout = 1; e.hiin = 1; push(e, 1'b1);
      end else begin
        e = blank(4'd6); e.zlowout = 1; e.rin = 16'd1 << ra; push(e, 1'b1);
      end
    end else if (op == 5'd11 || op == 5'd12) begin
      e = blank(4'd4); e.rout = 16'd1 << rb; e.alu = 13'd1 << op; e.zin = 1; push(e, 1'b1);
      e = blank(4'd5); e.zlowout = 1; e.rin = 16'd1 << ra; push(e, 1'b1);
    end else if (op == 5'd31) begin
      push(blank(4'd4), 1'b1);
    end else begin
      e = blank(4'd4); e.illegal = 1; push(e, 1'b1);
    end
  endtask

  // Drive inputs for the next edge, publish this cycle's expectation, advance.
  task automatic step(input outs_t e, input logic mr);
    mem_ready = mr;
    exp_now   = e;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int wait_n, output int base, output int len);
    IR = ir;
    build(ir, wait_n);
    base = hist.size();
    len  = plan.size();
    foreach (plan[i]) step(plan[i].e, plan[i].mr);
  endtask

  typedef struct {
    logic [31:0] ir;
    int          wait_n;
    int          len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b, n, cnt;
    reset = 1'b0; mem_ready = 1'b1; IR = '0;
    @(posedge clk); #1;
    step(blank(4'd0), 1'b1);
    reset = 1'b1;
    step(blank(4'd0), 1'b1);
    check("rst_all_zero", 128'(hist[1]), 128'(0));

    // ADD R4,R3,R7
    run_instr(32'h021B8000, 0, b, n);
    check("fetch_t0", 128'({hist[b].pcout, hist[b].marin, hist[b].incpc, hist[b].pcin}), 128'(4'hf));
    check("fetch_t1", 128'({hist[b+1].read, hist[b+1].mdrin}), 128'(2'b11));
    check("add_len", 128'(n), 128'(6));
    check("add_t3_rout", 128'(hist[b+3].rout), 128'(16'h0008));
    check("add_t3_yin", 128'(hist[b+3].yin), 128'(1));
    check("add_t4_rout", 128'(hist[b+4].rout), 128'(16'h0080));
    check("add_t4_op", 128'({hist[b+4].alu, hist[b+4].zin}), 128'({13'h0001, 1'b1}));
    check("add_t5_rin", 128'({hist[b+5].rin, hist[b+5].zlowout}), 128'({16'h0010, 1'b1}));
    check("add_next_t0", 128'(state), 128'(4'd1));

    // MUL R3,R7
    run_instr(32'h481B8000, 0, b, n);
    check("mul_len", 128'(n), 128'(7));
    check("mul_t4_op", 128'(hist[b+4].alu), 128'(13'h0200));
    check("mul_t5", 128'({hist[b+5].zlowout, hist[b+5].loin}), 128'(2'b11));
    check("mul_t6", 128'({hist[b+6].zhighout, hist[b+6].hiin}), 128'(2'b11));
    cnt = 0;
    for (int i = 0; i < 7; i++) cnt += int'(hist[b+i].rin != 16'h0);
    check("mul_no_rin", 128'(cnt), 128'(0));

    // NOT R2,R5
    run_instr(32'h61280000, 0, b, n);
    check("not_len", 128'(n), 128'(5));
    check("not_t3", 128'({hist[b+3].rout, hist[b+3].alu, hist[b+3].zin}), 128'({16'h0020, 13'h1000, 1'b1}));
    check("not_t4", 128'({hist[b+4].rin, hist[b+4].zlowout}), 128'({16'h0004, 1'b1}));
    check("not_next_t0", 128'(state), 128'(4'd1));

    // Memory wait of 3 cycles
    run_instr(32'h021B8000, 3, b, n);
    check("wait_len", 128'(n), 128'(9));
    cnt = 0;
    for (int i = 1; i <= 4; i++) cnt += int'(hist[b+i].read & hist[b+i].mdrin);
    check("wait_read_cycles", 128'(cnt), 128'(4));
    check("wait_then_t2", 128'(hist[b+5].state), 128'(4'd3));

    // Reset asserted in the middle of a memory wait
    IR = 32'h021B8000;
    build(32'h021B8000, 5);
    step(plan[0].e, 1'b1);
    step(plan[1].e, 1'b0);
    reset = 1'b0;
    step(plan[2].e, 1'b0);
    reset = 1'b1;
    step(blank(4'd0), 1'b1);
    check("midwait_rst", 128'(hist[hist.size()-1]), 128'(0));

    // More binary ops, with and without memory wait
    vecs[0] = '{mk_ir(5'd1, 4'd1, 4'd2, 4'd3), 0, 6};
    vecs[1] = '{mk_ir(5'd2, 4'd5, 4'd6, 4'd9), 0, 6};
    vecs[2] = '{mk_ir(5'd5, 4'd0, 4'd0, 4'd0), 0, 6};
    vecs[3] = '{mk_ir(5'd8, 4'd15, 4'd14, 4'd13), 0, 6};
    vecs[4] = '{mk_ir(5'd10, 4'd0, 4'd1, 4'd2), 1, 8};
    vecs[5] = '{mk_ir(5'd6, 4'd7, 4'd8, 4'd11), 2, 8};
    foreach (vecs[k]) begin
      run_instr(vecs[k].ir, vecs[k].wait_n, b, n);
      check($sformatf("vec%0d_len", k), 128'(n), 128'(vecs[k].len));
    end

    // NEG R0,R15: field value 0 selects R0
    run_instr(32'h58780000, 0, b, n);
    check("neg_t3_rout", 128'(hist[b+3].rout), 128'(16'h8000));
    check("neg_t4_rin", 128'(hist[b+4].rin), 128'(16'h0001));

    // Illegal opcodes
    run_instr(32'h80000000, 0, b, n);
    check("ill_len", 128'(n), 128'(4));
    check("ill_pulse", 128'({hist[b+2].illegal, hist[b+3].illegal}), 128'(2'b01));
    check("ill_next_t0", 128'(state), 128'(4'd1));
    run_instr(32'h68000000, 0, b, n);
    check("ill13_pulse", 128'(hist[b+3].illegal), 128'(1));

    // HALT: stays idle until reset
    run_instr(32'hF8000000, 0, b, n);
    for (int i = 0; i < 12; i++) step(blank(4'd8), (i % 2) == 0);
    cnt = 0;
    for (int i = b + 4; i < b + 16; i++) cnt += int'(hist[i].run == 1'b0 && hist[i].state == 4'd8);
    check("halt_idle_cycles", 128'(cnt), 128'(12));
    reset = 1'b0;
    step(blank(4'd8), 1'b1);
    reset = 1'b1;
    step(blank(4'd0), 1'b1);
    check("halt_rst_state", 128'(hist[hist.size()-1].state), 128'(4'd0));

    // Sequencing resumes after reset
    run_instr(32'h021B8000, 0, b, n);
    check("resume_t5_rin", 128'(hist[b+5].rin), 128'(16'h0010));

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired multi-cycle control unit that drives the datapath's control inputs: per-register in/out strobes, PC/MAR/MDR/IR/Y/Z/HI/LO enables, memory `Read` and the one-hot ALU operation selects. It is upstream of `datapath` and takes over the job the bench FSM does today.

On each instruction it runs fetch, waits on memory, decodes `IR`, and sequences one register-to-register ALU instruction. The next instruction then starts again at fetch.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `IR`  in  32  instruction register contents from `datapath`.
  - Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- `mem_ready`  in  1  memory read-data-valid; held-high tolerated.
- `Rin`  out  16  one-hot register write enables; bit n drives `Rn`in.
- `Rout`  out  16  one-hot register bus drives; bit n drives `Rn`out.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Read`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `HIin`, `LOin`  out  1 each  datapath strobes.
- `AND`, `OR`, `ADD`, `SUB`, `MUL`, `DIV`, `SHR`, `SHRA`, `SHL`, `ROR`, `ROL`, `NEG`, `NOT`  out  1 each  ALU op selects; at most one is high.
- `run`  out  1  high while sequencing, low in HALT and during reset.
- `illegal`  out  1  one-cycle pulse when an undefined opcode is decoded.
- `state`  out  4  current state code, for debug only.

## Operation
- States and codes:
  - S_RST=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
- All outputs are Moore-decoded from `state` plus the registered `IR` fields. Every strobe is 0 in any state not listed below.
- Opcodes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011, SHR 00100, SHRA 00101, SHL 00110, ROR 00111, ROL 01000.
  - MUL 01001, DIV 01010, NEG 01011, NOT 01100, HALT 11111.
  - All other opcodes are illegal.
- Per-state actions:
  - S_RST: all strobes 0. Next state T0.
  - T0: `PCout`, `MARin`, `IncPC`, `PCin`. Next state T1.
  - T1: `Read`, `MDRin`. Stays in T1 while `mem_ready`=0 and holds both strobes; moves to T2 when `mem_ready`=1.
  - T2: `MDRout`, `IRin`. Next state T3.
  - T3: decode step.
    - Binary ops: `Rout[Rb]`, `Yin`. Next state T4.
    - NEG/NOT: `Rout[Rb]`, op select, `Zin`. Next state T4.
    - Illegal opcode: no strobes, `illegal`=1. Next state T0.
    - HALT opcode: no strobes. Next state HALT.
  - T4:
    - Binary ops: `Rout[Rc]`, op select, `Zin`. Next state T5.
    - NEG/NOT: `Zlowout`, `Rin[Ra]`. Next state T0.
  - T5:
    - MUL/DIV: `Zlowout`, `LOin`. Next state T6.
    - Other binary ops: `Zlowout`, `Rin[Ra]`. Next state T0.
  - T6 (MUL/DIV only): `Zhighout`, `HIin`. Next state T0. MUL/DIV never write `Rin`.
  - HALT: all strobes 0, `run`=0. Stays in HALT until reset.
- `Rin`/`Rout` decode the 4-bit field to one-hot; field 0 selects R0 like any other register.
- No two bus drivers are ever high in the same cycle: at most one of `Rout`, `PCout`, `MDRout`, `Zlowout`, `Zhighout` is nonzero.

## Timing
- Reset: when `reset`=0 at a rising edge, the next state is S_RST and every output is 0, including `run`, `illegal` and all strobes. `state` reads 0.
  - This takes priority over any state, including a T1 memory wait or HALT.
  - An in-flight instruction is abandoned with no further strobes.
- `run` is 1 in T0 through T6 and 0 in S_RST and HALT.
- Latency in cycles from T0 entry to the next T0 entry, with zero memory wait:
  - Binary ALU ops: 6.
  - MUL/DIV: 7.
  - NEG/NOT: 5.
  - Illegal opcode: 4.
  - Each cycle `mem_ready` stays low in T1 adds 1.
- `mem_ready` is sampled only in T1 and ignored in every other state.
- `IR` is sampled from T3 onward. The IR value written at the end of T2 is the value decoded.

## Test plan
- Reset and fetch:
  - Stimulus: `reset`=0 for 2 cycles, then 1, with `mem_ready`=1.
  - Required: all outputs 0 and `state`=0 during reset. The next cycle is T0 with `PCout`, `MARin`, `IncPC`, `PCin` = 1, then T1 with `Read`, `MDRin` = 1.
- ADD R4,R3,R7:
  - Stimulus: `IR`=0x021B8000.
  - Required: T3 `Rout`=0x0008 with `Yin`; T4 `Rout`=0x0080 with `ADD` and `Zin`; T5 `Zlowout` with `Rin`=0x0010; then T0. Total 6 cycles.
- MUL R3,R7:
  - Stimulus: `IR`=0x481B8000.
  - Required: T4 `MUL`=1; T5 `Zlowout` with `LOin`; T6 `Zhighout` with `HIin`; `Rin`=0 throughout. Total 7 cycles.
- NOT R2,R5:
  - Stimulus: `IR`=0x61280000.
  - Required: T3 `Rout`=0x0020 with `NOT` and `Zin`; T4 `Zlowout` with `Rin`=0x0004; then T0. Total 5 cycles.
- Memory wait and reset mid-wait:
  - Stimulus: hold `mem_ready`=0 for 3 cycles in T1.
  - Required: `Read` and `MDRin` stay high for 4 cycles, then T2.
  - Stimulus: repeat the wait and assert `reset`=0 during it.
  - Required: the next cycle is S_RST with all strobes 0.
- Illegal and HALT:
  - Stimulus: `IR`=0x80000000.
  - Required: `illegal` pulses for 1 cycle in T3, then T0.
  - Stimulus: `IR`=0xF8000000.
  - Required: HALT is entered and `run`=0 with all strobes 0 for 10 or more cycles, until reset.
